// File: rtl/ysyx_22050058_ifu_pkg.sv
// Shared definitions for the ysyx_22050058 instruction fetch unit.
//   - default address / instruction widths and the fetch-entry width
//   - reset PC constant
//   - FSM state encoding
//   - fetch-entry struct for the default configuration
package ysyx_22050058_ifu_pkg;

    localparam int unsigned IFU_ADDR_W  = 64;
    localparam int unsigned IFU_INST_W  = 32;
    localparam int unsigned IFU_ENTRY_W = IFU_ADDR_W + IFU_INST_W;

    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHalt  = 2'd2
    } ifu_state_e;

    // Layout of one queue entry: {pc, inst}, pc in the upper bits.
    typedef struct packed {
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ysyx_22050058_ifu_fifo2.sv
// Two-entry synchronous queue used between fetch and decode.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail (ignored when full without pop)
//   push_data   : entry to write
//   pop         : drop the head entry (ignored when empty)
//   flush       : discard all entries; takes priority over push/pop
//   count       : number of valid entries (0..2)
//   head        : head entry; holds its last value when the queue is empty
module ysyx_22050058_ifu_fifo2
    import ysyx_22050058_ifu_pkg::*;
#(
    parameter int unsigned WIDTH = IFU_ENTRY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    // slot0 is always the head; slot1 is the second entry.
    logic [WIDTH-1:0] slot0_q, slot0_d;
    logic [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       count_q, count_d;
    logic             push_ok, pop_ok;

    assign pop_ok  = pop & (count_q != 2'd0);
    assign push_ok = push & ((count_q != 2'd2) | pop_ok);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) slot0_d = push_data;
                    else                 slot1_d = push_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) slot0_d = slot1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        slot0_d = push_data;
                    end else begin
                        slot0_d = slot1_q;
                        slot1_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = slot0_q;

endmodule

// File: rtl/ysyx_22050058_ifu.sv
// Instruction fetch unit.
// Drives the combinational instruction ROM (rom_ce/rom_addr -> rom_inst in the
// same cycle), buffers fetched {pc, inst} pairs in a 2-entry queue and hands
// them to decode over out_valid/out_ready. Handles redirects and halt requests.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rom_ce, rom_addr, rom_inst  : ROM fetch interface
//   redirect_valid, redirect_pc : branch/jump redirect (flushes the queue)
//   halt_req                    : stop fetching until the next redirect
//   out_valid, out_ready        : decode handshake
//   out_pc, out_inst            : head entry
//   fetch_fault                 : sticky misaligned-redirect flag
// Optional feature: define YSYX_22050058_IFU_MISALIGN_EN to halt and raise
// fetch_fault on a redirect whose target is not 4-byte aligned.
module ysyx_22050058_ifu
    import ysyx_22050058_ifu_pkg::*;
#(
    parameter int unsigned          ADDR_W   = IFU_ADDR_W,
    parameter int unsigned          INST_W   = IFU_INST_W,
    parameter logic [ADDR_W-1:0]    RESET_PC = IFU_RESET_PC[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              fetch_fault
);

    localparam int unsigned EntryW = ADDR_W + INST_W;

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        count;
    logic [EntryW-1:0] head;
    logic              queue_valid;
    logic              pop;
    logic              fetch;
    logic              redirect_misaligned;

`ifdef YSYX_22050058_IFU_MISALIGN_EN
    logic fault_q, fault_d;

    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    // A redirect always rewrites the flag: misaligned sets it, aligned clears it.
    assign fault_d = redirect_valid ? redirect_misaligned : fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end

    assign fetch_fault = fault_q;
`else
    assign redirect_misaligned = 1'b0;
    assign fetch_fault         = 1'b0;
`endif

    assign queue_valid = (count != 2'd0);
    assign pop         = queue_valid & out_ready;
    // A pop frees a slot in the same cycle, so a full queue still fetches.
    assign fetch = (state_q == StFetch) & ~redirect_valid & ~halt_req
                 & ((count != 2'd2) | pop);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state: redirect wins over everything else.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = redirect_misaligned ? StHalt : StFetch;
        end else begin
            if (fetch) pc_d = pc_q + ADDR_W'(4);
            unique case (state_q)
                StIdle:  state_d = halt_req ? StHalt : StFetch;
                StFetch: if (halt_req) state_d = StHalt;
                StHalt:  ;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        rom_ce    = fetch;
        rom_addr  = pc_q;
        out_valid = queue_valid;
        out_pc    = head[EntryW-1:INST_W];
        out_inst  = head[INST_W-1:0];
    end

    ysyx_22050058_ifu_fifo2 #(
        .WIDTH (EntryW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fetch),
        .push_data ({pc_q, rom_inst}),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

endmodule
